dump_stage: RTL

Final pipeline stage of the SHAKE core. It takes squeezed rate blocks from the permutation stage and serializes them into `W`-bit words on a `valid_o`/`ready_o` output interface. It stops after exactly `output_size` bits and requests further squeeze blocks through a buffer-ready handshake. It is the transmit-side counterpart of the load stage.

---
 rtl/dump_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/dump_stage.sv
// Final SHAKE stage: serializes squeezed rate blocks into W-bit words on a valid/ready port.
// Optional macro DUMP_MASK_TAIL_EN zeroes the unused upper bits of the final word.
//
// state  | meaning
// S_IDLE | waiting for the first block of a new message
// S_DUMP | presenting words of the current block
// S_WAIT | block drained, message not done; waiting for the next squeeze block
module dump_stage #(
  parameter int W    = 64,
  parameter int RATE = 1344
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RATE-1:0] rate_output,
  input  logic [31:0]     output_size,
  input  logic [1:0]      operation_mode,
  input  logic            output_buffer_ready,
  output logic            output_buffer_ready_wr,
  output logic            squeeze_done_wr,
  output logic [W-1:0]    data_o,
  output logic            valid_o,
  output logic            last_o,
  input  logic            ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_DUMP, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [RATE-1:0] blk;
  logic [31:0]     rem_bits;
  logic [4:0]      wcnt;
  logic [4:0]      wpb;
  logic            load_first;
  logic            load_next;
  logic            take;

  assign valid_o = (state == S_DUMP);
  // Compare before subtract, so rem_bits never wraps even for 2^32-1.
  assign last_o  = valid_o && (rem_bits <= 32'(W));
  assign take    = valid_o && ready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (output_buffer_ready) begin
          load_first = 1'b1;
          if (output_size != 32'd0) state_nxt = S_DUMP;
        end
      end
      S_DUMP: begin
        if (ready_o) begin
          if (last_o)                   state_nxt = S_IDLE;
          else if (wcnt == wpb - 5'd1)  state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (output_buffer_ready) begin
          load_next = 1'b1;
          state_nxt = S_DUMP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk                    <= '0;
      rem_bits               <= '0;
      wcnt                   <= '0;
      wpb                    <= 5'd21;
      output_buffer_ready_wr <= 1'b0;
      squeeze_done_wr        <= 1'b0;
    end else begin
      output_buffer_ready_wr <= load_first | load_next;
      squeeze_done_wr        <= (load_first && (output_size == 32'd0)) || (take && last_o);
      if (load_first) begin
        rem_bits <= output_size;
        wpb      <= (operation_mode == 2'b01) ? 5'd17 : 5'd21;
      end
      if (load_first || load_next) begin
        blk  <= rate_output;
        wcnt <= '0;
      end else if (take) begin
        blk <= blk >> W;
        if (last_o) begin
          rem_bits <= '0;
        end else begin
          rem_bits <= rem_bits - 32'(W);
          wcnt     <= wcnt + 5'd1;
        end
      end
    end
  end

`ifdef DUMP_MASK_TAIL_EN
  always_comb begin
    data_o = '0;
    for (int i = 0; i < W; i++) begin
      data_o[i] = blk[i] & (~last_o | (rem_bits > 32'(i)));
    end
  end
`else
  assign data_o = blk[W-1:0];
`endif

endmodule
